// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule applied when an op is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // A dword access is only legal on a 64-bit datapath.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] low,
                                         input logic       dword_ok);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = low[0];
      SZ_W:    bad = |low[1:0];
      SZ_D:    bad = !dword_ok || (|low);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding system.
interface lsu_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              stall;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              err_misalign;
  logic              err_timeout;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_rdata, mem_ack,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_rd, err_misalign, err_timeout,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_rdata, mem_ack,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_rd, err_misalign, err_timeout,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: stores shift data up into its lane, loads shift it
// down and sign/zero-extend the accessed width.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       load,
  input  logic [1:0]                 size,
  input  logic                       unsigned_ext,
  input  logic [$clog2(XLEN/8)-1:0]  lane,
  input  logic [XLEN-1:0]            data_in,
  output logic [XLEN-1:0]            data_out
);

  logic [XLEN-1:0] shifted_s;
  logic [7:0]      keep_s;
  logic            sign_s;

  // Lane shift followed by extension above the accessed width
  always_comb begin
    shifted_s = '0;
    keep_s    = 8'd0;
    sign_s    = 1'b0;
    data_out  = '0;
    if (load) begin
      shifted_s = data_in >> {lane, 3'b000};
    end else begin
      shifted_s = data_in << {lane, 3'b000};
    end
    case (size)
      SZ_B: begin
        keep_s = 8'd8;
        sign_s = shifted_s[7];
      end
      SZ_H: begin
        keep_s = 8'd16;
        sign_s = shifted_s[15];
      end
      SZ_W: begin
        keep_s = 8'd32;
        sign_s = shifted_s[31];
      end
      default: begin
        keep_s = 8'(XLEN);
        sign_s = shifted_s[XLEN-1];
      end
    endcase
    // A full-width access keeps every bit, so unsigned_ext has no effect there
    for (int i = 0; i < XLEN; i++) begin
      if (!load || (8'(i) < keep_s)) begin
        data_out[i] = shifted_s[i];
      end else begin
        data_out[i] = ~unsigned_ext & sign_s;
      end
    end
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory op at a time from the pipeline, runs
// the data-memory handshake with a bounded wait and returns extended loads.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_unit_if.slave bus
);

  localparam int   NB       = XLEN / 8;
  localparam int   LANE_W   = $clog2(NB);
  localparam int   CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic DWORD_OK = (XLEN == 64);

  lsu_state_e        state_r, state_n;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic              we_r;
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   wdata_r;
  logic [NB-1:0]     be_r;
  logic [XLEN-1:0]   rdata_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              err_misalign_r;
  logic              err_timeout_r;

  logic              accept_s;
  logic              misalign_s;
  logic              timeout_s;
  logic              ack_s;
  logic [NB-1:0]     be_s;
  logic [XLEN-1:0]   st_data_s;
  logic [XLEN-1:0]   ld_data_s;

  lsu_lane_align #(.XLEN(XLEN)) u_store_align (
    .load         (1'b0),
    .size         (bus.req_size),
    .unsigned_ext (bus.req_unsigned),
    .lane         (bus.req_addr[LANE_W-1:0]),
    .data_in      (bus.req_wdata),
    .data_out     (st_data_s)
  );

  lsu_lane_align #(.XLEN(XLEN)) u_load_align (
    .load         (1'b1),
    .size         (size_r),
    .unsigned_ext (unsigned_r),
    .lane         (addr_r[LANE_W-1:0]),
    .data_in      (bus.mem_rdata),
    .data_out     (ld_data_s)
  );

  // Byte-enable mask of the presented request, positioned at its lane
  always_comb begin
    be_s = '0;
    case (bus.req_size)
      SZ_B:    be_s = NB'(4'h1);
      SZ_H:    be_s = NB'(4'h3);
      SZ_W:    be_s = NB'(4'hF);
      default: be_s = NB'(8'hFF);
    endcase
    be_s = be_s << bus.req_addr[LANE_W-1:0];
  end

  // Next-state logic and one-cycle event strobes
  always_comb begin
    state_n    = state_r;
    accept_s   = 1'b0;
    misalign_s = 1'b0;
    timeout_s  = 1'b0;
    ack_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          accept_s   = 1'b1;
          misalign_s = is_misaligned(bus.req_size, bus.req_addr[2:0], DWORD_OK);
          if (misalign_s) begin
            state_n = IDLE;
          end else begin
            state_n = ACCESS;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        // An ack on the last permitted cycle beats the timeout
        if (bus.mem_ack) begin
          ack_s = 1'b1;
          if (we_r) begin
            state_n = IDLE;
          end else begin
            state_n = RESP;
          end
        end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = ACCESS;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Op fields captured at acceptance; store data and enables pre-positioned
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= '0;
      size_r     <= 2'd0;
      unsigned_r <= 1'b0;
      we_r       <= 1'b0;
      rd_r       <= 5'd0;
      wdata_r    <= '0;
      be_r       <= '0;
    end else if (accept_s) begin
      addr_r     <= bus.req_addr;
      size_r     <= bus.req_size;
      unsigned_r <= bus.req_unsigned;
      we_r       <= bus.req_we;
      rd_r       <= bus.req_rd;
      wdata_r    <= bus.req_we ? st_data_s : '0;
      be_r       <= bus.req_we ? be_s : '0;
    end
  end

  // Counts ACCESS cycles that passed without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ACCESS) && (state_n == ACCESS)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Load data captured at the ack, plus the error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r        <= '0;
      err_misalign_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      err_misalign_r <= misalign_s;
      err_timeout_r  <= timeout_s;
      if (ack_s && !we_r) begin
        rdata_r <= ld_data_s;
      end
    end
  end

  assign bus.req_ready    = (state_r == IDLE);
  assign bus.stall        = (state_r == ACCESS);
  assign bus.mem_en       = (state_r == ACCESS);
  assign bus.mem_we       = (state_r == ACCESS) & we_r;
  assign bus.mem_addr     = {addr_r[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign bus.mem_wdata    = wdata_r;
  assign bus.mem_be       = be_r;
  assign bus.rsp_valid    = (state_r == RESP);
  assign bus.rsp_rdata    = rdata_r;
  assign bus.rsp_rd       = rd_r;
  assign bus.err_misalign = err_misalign_r;
  assign bus.err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit (XLEN=32, TIMEOUT=4): directed corner
// cases followed by random ops compared against an arithmetic model.
module tb_lsu_unit;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  lsu_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  lsu_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte addresses
  function automatic bit ref_misaligned(input int size, input int addr);
    return (size == 3) || ((addr % (1 << size)) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input int size, input int addr);
    int m;
    m = ((1 << (1 << size)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wdata, input int addr);
    longint unsigned w;
    w = 64'(wdata) << (8 * (addr % 4));
    return w[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int size,
                                           input bit uns, input int addr);
    longint unsigned v, lim;
    int bits;
    bits = 8 << size;
    v = 64'(rdata) >> (8 * (addr % 4));
    if (bits >= 32) return v[31:0];
    lim = 64'd1 << bits;
    v = v % lim;
    if (!uns && (v >= lim / 2)) v = v - lim;
    return v[31:0];
  endfunction

  task automatic check_idle_clean(input string tag);
    check_eq({tag, "_ready"},     bus.req_ready, 1'b1);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check_eq({tag, "_err_mis"},   bus.err_misalign, 1'b0);
    check_eq({tag, "_err_to"},    bus.err_timeout, 1'b0);
    check_eq({tag, "_mem_en"},    bus.mem_en, 1'b0);
    check_eq({tag, "_stall"},     bus.stall, 1'b0);
  endtask

  // Runs one op starting at a negedge with the unit idle; ack_delay >= TIMEOUT means no ack
  task automatic lsu_op(input bit we, input int size, input bit uns, input int addr,
                        input logic [31:0] wdata, input int rd, input int ack_delay,
                        input logic [31:0] rdata);
    bit done;
    check_idle_clean("pre");
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size[1:0];
    bus.req_unsigned = uns;
    bus.req_addr     = addr[13:0];
    bus.req_wdata    = wdata;
    bus.req_rd       = rd[4:0];
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (ref_misaligned(size, addr)) begin
      check_eq("mis_pulse", bus.err_misalign, 1'b1);
      check_eq("mis_mem_en", bus.mem_en, 1'b0);
      check_eq("mis_ready", bus.req_ready, 1'b1);
      check_eq("mis_stall", bus.stall, 1'b0);
      @(negedge clk);
    end else begin
      done = 1'b0;
      for (int k = 0; k < TIMEOUT && !done; k++) begin
        check_eq("acc_stall", bus.stall, 1'b1);
        check_eq("acc_mem_en", bus.mem_en, 1'b1);
        check_eq("acc_ready", bus.req_ready, 1'b0);
        check_eq("acc_mem_we", bus.mem_we, we);
        check_eq("acc_mem_addr", bus.mem_addr, addr & 32'h3FFC);
        check_eq("acc_mem_be", bus.mem_be, we ? ref_be(size, addr) : 4'h0);
        if (we) check_eq("acc_mem_wdata", bus.mem_wdata, ref_wdata(wdata, addr));
        // Requests presented while busy must be ignored
        bus.req_valid = 1'($urandom % 2);
        bus.req_addr  = 14'($urandom);
        if (k == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
          done = 1'b1;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
      end
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'b0;
      if (done && !we) begin
        check_eq("rsp_valid", bus.rsp_valid, 1'b1);
        check_eq("rsp_rdata", bus.rsp_rdata, ref_load(rdata, size, uns, addr));
        check_eq("rsp_rd", bus.rsp_rd, rd[4:0]);
        check_eq("rsp_stall", bus.stall, 1'b0);
        check_eq("rsp_ready", bus.req_ready, 1'b0);
        check_eq("rsp_err_to", bus.err_timeout, 1'b0);
        @(negedge clk);
      end else if (done) begin
        check_eq("st_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("st_ready", bus.req_ready, 1'b1);
        check_eq("st_err_to", bus.err_timeout, 1'b0);
        check_eq("st_mem_en", bus.mem_en, 1'b0);
      end else begin
        check_eq("to_pulse", bus.err_timeout, 1'b1);
        check_eq("to_ready", bus.req_ready, 1'b1);
        check_eq("to_stall", bus.stall, 1'b0);
        check_eq("to_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_stray_ack();
    bus.mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_idle_clean("stray_ack");
  endtask

  initial begin
    int size, addr;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = 5'd0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 1'b1);
    check_eq("rst_stall", bus.stall, 1'b0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_rd", bus.rsp_rd, 5'd0);
    check_eq("rst_err_mis", bus.err_misalign, 1'b0);
    check_eq("rst_err_to", bus.err_timeout, 1'b0);
    check_eq("rst_mem_en", bus.mem_en, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 14'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_mem_be", bus.mem_be, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corners
    lsu_op(1'b1, 0, 1'b0, 32'h3, 32'h000000A5, 0, 0, 32'h0);
    lsu_op(1'b0, 0, 1'b0, 32'h2, 32'h0, 7, 0, 32'h0080FF00);
    lsu_op(1'b0, 0, 1'b1, 32'h2, 32'h0, 7, 0, 32'h0080FF00);
    lsu_op(1'b0, 1, 1'b0, 32'h1, 32'h0, 3, 0, 32'h0);
    lsu_op(1'b0, 2, 1'b0, 32'h8, 32'h0, 4, TIMEOUT + 2, 32'h12345678);
    lsu_op(1'b0, 2, 1'b0, 32'h8, 32'h0, 4, TIMEOUT - 1, 32'h87654321);
    lsu_op(1'b0, 2, 1'b1, 32'hC, 32'h0, 9, 0, 32'h80000001);
    lsu_op(1'b0, 3, 1'b0, 32'h10, 32'h0, 1, 0, 32'h0);
    idle_stray_ack();

    // Reset while waiting in ACCESS abandons the load silently
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 14'h10; bus.req_rd = 5'd5;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rstacc_mem_en1", bus.mem_en, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_eq("rstacc_stall2", bus.stall, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstacc_mem_en", bus.mem_en, 1'b0);
    check_eq("rstacc_rsp_rd", bus.rsp_rd, 5'd0);
    check_idle_clean("rstacc");
    @(negedge clk);
    check_idle_clean("rstacc_after");

    // Back-to-back word load then word store with two wait cycles each
    lsu_op(1'b0, 2, 1'b0, 32'h20, 32'h0, 12, 2, 32'hCAFEF00D);
    lsu_op(1'b1, 2, 1'b0, 32'h24, 32'hDEADBEEF, 0, 2, 32'h0);

    // Random ops
    for (int n = 0; n < 250; n++) begin
      size = $urandom_range(0, 3);
      addr = $urandom_range(0, 16383);
      if ($urandom % 4 != 0) addr = addr & ~((1 << size) - 1);
      if ($urandom % 10 == 0) idle_stray_ack();
      lsu_op(1'($urandom % 2), size, 1'($urandom % 2), addr, $urandom,
             $urandom_range(0, 31), $urandom_range(0, TIMEOUT + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
